// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg
//   Shared definitions for the HI/LO multiply/divide unit.
//   - MD_OP_*  : 2-bit operation codes that EX drives on `op`.
//   - md_state_e : FSM state codes (IDLE/MUL/DIV/DONE).
//   - md_cneg  : conditional two's-complement negate, used for the sign
//                fix-up around the unsigned divider.
package muldiv_ctrl_pkg;

    localparam logic [1:0] MD_OP_MULT  = 2'd0;
    localparam logic [1:0] MD_OP_MULTU = 2'd1;
    localparam logic [1:0] MD_OP_DIV   = 2'd2;
    localparam logic [1:0] MD_OP_DIVU  = 2'd3;

    typedef enum logic [1:0] {
        MD_ST_IDLE = 2'd0,
        MD_ST_MUL  = 2'd1,
        MD_ST_DIV  = 2'd2,
        MD_ST_DONE = 2'd3
    } md_state_e;

    function automatic logic [31:0] md_cneg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_core.sv
// div_core
//   Unsigned 32/32 restoring divider, one quotient bit per `step`.
//   Ports:
//     clk, rst   : clock, synchronous active-high reset
//     load       : capture dividend/divisor and clear the iteration count
//     dividend   : unsigned dividend (captured on load)
//     divisor    : unsigned divisor  (captured on load, must be non-zero)
//     step       : perform one iteration this cycle
//     quotient   : quotient after this cycle's step (registered value if no step)
//     remainder  : remainder after this cycle's step (registered value if no step)
//     last       : this cycle's step is the 32nd, so quotient/remainder are final
module div_core
    import muldiv_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        step,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic [4:0]  r_cnt;

    logic [32:0] w_shift;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_quo_nx;
    logic [31:0] w_rem_nx;

    // Partial remainder shifted left with the next dividend bit brought in.
    // Because rem < divisor, the shifted value is < 2*divisor, so a set bit 32
    // of the trial difference means the subtraction went negative.
    assign w_shift  = {r_rem, r_quo[31]};
    assign w_trial  = w_shift - {1'b0, r_div};
    assign w_ge     = ~w_trial[32];
    assign w_quo_nx = {r_quo[30:0], w_ge};
    assign w_rem_nx = w_ge ? w_trial[31:0] : w_shift[31:0];

    // Outputs look through the current step so the controller can commit on
    // the same edge that performs the final iteration.
    assign quotient  = step ? w_quo_nx : r_quo;
    assign remainder = step ? w_rem_nx : r_rem;
    assign last      = step && (r_cnt == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_div <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_div <= divisor;
            r_cnt <= '0;
        end else if (step) begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
            r_cnt <= r_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Multi-cycle HI/LO unit beside EX: sequences MULT/MULTU/DIV/DIVU, owns the
//   HI/LO pair, stalls IF..EX while busy, services MTHI/MTLO, and aborts on
//   exception flush.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     flush         : exception flush, aborts any operation without commit
//     start, op     : EX holds a mul/div instruction with opcode MD_OP_*
//     src_a, src_b  : rs / rt operand values
//     we_hi, we_lo  : MTHI / MTLO strobes, wdata is the value written
//     stall         : combinational pipeline hold for this cycle
//     done          : one-cycle pulse, HI/LO were committed on entry to it
//     hilo          : {HI, LO}
//   Handshake: EX raises start and holds the instruction while stall is high;
//   the cycle with stall low and done high is the one where EX advances.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        we_hi,
    input  logic        we_lo,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [63:0] hilo
);

    localparam logic [5:0] MUL_CNT_LAST = 6'(MUL_LATENCY - 1);

    md_state_e   r_state;
    md_state_e   w_state_nx;
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_a;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic [63:0] r_mul_pipe [MUL_LATENCY];

    logic        w_accept;
    logic        w_is_div;
    logic        w_signed_div;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_prod;
    logic        w_div_load;
    logic        w_div_step;
    logic [31:0] w_quo;
    logic [31:0] w_rem;
    logic        w_div_last;
    logic        w_commit;
    logic [63:0] w_commit_hilo;

    assign w_accept     = (r_state == MD_ST_IDLE) && start && !flush;
    assign w_is_div     = op[1];
    assign w_signed_div = (op == MD_OP_DIV);

    // Operands sign/zero-extended to 64 bits; the low 64 bits of this product
    // equal the full 33x33 signed product. Fed straight from EX operands, which
    // are held stable for the whole operation, so pipe[L-1] is valid in the
    // last MUL cycle.
    assign w_ma   = {{32{(op == MD_OP_MULT) && src_a[31]}}, src_a};
    assign w_mb   = {{32{(op == MD_OP_MULT) && src_b[31]}}, src_b};
    assign w_prod = w_ma * w_mb;

    always_ff @(posedge clk) begin
        r_mul_pipe[0] <= w_prod;
        for (int i = 1; i < MUL_LATENCY; i++) begin
            r_mul_pipe[i] <= r_mul_pipe[i-1];
        end
    end

    assign w_div_load = w_accept && w_is_div;
    assign w_div_step = (r_state == MD_ST_DIV) && !r_dz;

    div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (w_div_load),
        .dividend  (md_cneg(src_a, w_signed_div && src_a[31])),
        .divisor   (md_cneg(src_b, w_signed_div && src_b[31])),
        .step      (w_div_step),
        .quotient  (w_quo),
        .remainder (w_rem),
        .last      (w_div_last)
    );

    always_comb begin
        w_state_nx    = r_state;
        w_commit      = 1'b0;
        w_commit_hilo = '0;
        case (r_state)
            MD_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_is_div ? MD_ST_DIV : MD_ST_MUL;
                end
            end
            MD_ST_MUL: begin
                if (r_cnt == MUL_CNT_LAST) begin
                    w_state_nx    = MD_ST_DONE;
                    w_commit      = 1'b1;
                    w_commit_hilo = r_mul_pipe[MUL_LATENCY-1];
                end
            end
            MD_ST_DIV: begin
                if (r_dz) begin
                    w_state_nx    = MD_ST_DONE;
                    w_commit      = 1'b1;
                    w_commit_hilo = {r_a, 32'hFFFF_FFFF};
                end else if (w_div_last) begin
                    w_state_nx    = MD_ST_DONE;
                    w_commit      = 1'b1;
                    w_commit_hilo = {md_cneg(w_rem, r_neg_r), md_cneg(w_quo, r_neg_q)};
                end
            end
            MD_ST_DONE: begin
                w_state_nx = MD_ST_IDLE;
            end
            default: begin
                w_state_nx = MD_ST_IDLE;
            end
        endcase
        if (flush) begin
            w_state_nx = MD_ST_IDLE;
            w_commit   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MD_ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= (r_state == MD_ST_MUL) ? r_cnt + 6'd1 : 6'd0;
            if (w_accept) begin
                r_a     <= src_a;
                r_neg_q <= w_signed_div && (src_a[31] ^ src_b[31]);
                r_neg_r <= w_signed_div && src_a[31];
                r_dz    <= (src_b == 32'd0);
            end
            // Moves to HI/LO are only honoured from IDLE; commits can only
            // happen from MUL/DIV, so the two never collide.
            if (w_commit) begin
                r_hi <= w_commit_hilo[63:32];
                r_lo <= w_commit_hilo[31:0];
            end else if ((r_state == MD_ST_IDLE) && !flush) begin
                if (we_hi) r_hi <= wdata;
                if (we_lo) r_lo <= wdata;
            end
        end
    end

    assign stall = !rst && !flush &&
                   (((r_state == MD_ST_IDLE) && start) ||
                    (r_state == MD_ST_MUL) || (r_state == MD_ST_DIV));
    assign done  = (r_state == MD_ST_DONE);
    assign hilo  = {r_hi, r_lo};

    a_no_move_while_busy: assert property (@(posedge clk) disable iff (rst)
        ((r_state == MD_ST_MUL) || (r_state == MD_ST_DIV)) |-> !(we_hi || we_lo));

endmodule

// File: tb/tb_muldiv_ctrl.sv
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        we_hi = 1'b0;
    logic        we_lo = 1'b0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic        done;
    logic [63:0] hilo;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MUL_LATENCY(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .start (start),
        .op    (op),
        .src_a (src_a),
        .src_b (src_b),
        .we_hi (we_hi),
        .we_lo (we_lo),
        .wdata (wdata),
        .stall (stall),
        .done  (done),
        .hilo  (hilo)
    );

    // ---------------- scoreboard ----------------
    int n_total = 0;
    int n_pass  = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after posedge; outputs sampled 4 later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver ----------------
    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] hilo;
        int          stall_cyc;
    } vec_t;

    vec_t vecs[14];

    task automatic run_op(input vec_t v);
        int cyc;
        logic [63:0] exp_hilo;
        next_cycle();
        start = 1'b1;
        op    = v.op;
        src_a = v.a;
        src_b = v.b;
        exp_q.push_back(v.hilo);
        cyc = 0;
        #4;
        while (stall === 1'b1 && cyc < 100) begin
            cyc++;
            @(posedge clk);
            #5;
        end
        exp_hilo = exp_q.pop_front();
        check({v.name, " stall_cycles"}, 64'(cyc), 64'(v.stall_cyc));
        check({v.name, " done"}, 64'(done), 64'd1);
        check({v.name, " hilo"}, hilo, exp_hilo);
        next_cycle();
        start = 1'b0;
        #4;
        check({v.name, " done_drop"}, 64'(done), 64'd0);
    endtask

    // ---------------- test ----------------
    initial begin
        vecs[0]  = '{"divu_100_7",   MD_OP_DIVU,  32'd100,       32'd7,         {32'd2, 32'd14},                  33};
        vecs[1]  = '{"div_m7_2",     MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD},   33};
        vecs[2]  = '{"div_min_m1",   MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000},           33};
        vecs[3]  = '{"mult_m1_2",    MD_OP_MULT,  32'hFFFF_FFFF, 32'd2,         64'hFFFF_FFFF_FFFF_FFFE,          3};
        vecs[4]  = '{"multu_m1_2",   MD_OP_MULTU, 32'hFFFF_FFFF, 32'd2,         64'h0000_0001_FFFF_FFFE,          3};
        vecs[5]  = '{"divu_5_0",     MD_OP_DIVU,  32'd5,         32'd0,         {32'd5, 32'hFFFF_FFFF},           2};
        vecs[6]  = '{"div_7_m2",     MD_OP_DIV,   32'd7,         32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD},           33};
        vecs[7]  = '{"div_m8_m3",    MD_OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, {32'hFFFF_FFFE, 32'd2},           33};
        vecs[8]  = '{"mult_min_min", MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000,          3};
        vecs[9]  = '{"multu_max",    MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,          3};
        vecs[10] = '{"mult_m1_m1",   MD_OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001,          3};
        vecs[11] = '{"div_m7_0",     MD_OP_DIV,   32'hFFFF_FFF9, 32'd0,         {32'hFFFF_FFF9, 32'hFFFF_FFFF},   2};
        vecs[12] = '{"divu_max_1",   MD_OP_DIVU,  32'hFFFF_FFFF, 32'd1,         {32'd0, 32'hFFFF_FFFF},           33};
        vecs[13] = '{"divu_hex",     MD_OP_DIVU,  32'h1234_5678, 32'h0000_1000, {32'h0000_0678, 32'h0001_2345},   33};

        // Reset: stall forced low even with start asserted.
        start = 1'b1;
        repeat (3) next_cycle();
        #4;
        check("rst_stall_forced", 64'(stall), 64'd0);
        next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        #4;
        check("reset_hilo", hilo, 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_stall", 64'(stall), 64'd0);

        // Start with flush in IDLE: no stall, nothing launched.
        next_cycle();
        start = 1'b1;
        flush = 1'b1;
        op    = MD_OP_DIVU;
        src_a = 32'd10;
        src_b = 32'd3;
        #4;
        check("idle_flush_stall", 64'(stall), 64'd0);
        next_cycle();
        start = 1'b0;
        flush = 1'b0;
        #4;
        check("idle_flush_nostart", 64'({stall, done}), 64'd0);

        foreach (vecs[i]) run_op(vecs[i]);

        // MTHI/MTLO then DIVU flushed at iteration 10.
        next_cycle();
        we_hi = 1'b1;
        wdata = 32'h11;
        next_cycle();
        we_hi = 1'b0;
        we_lo = 1'b1;
        wdata = 32'h22;
        next_cycle();
        we_lo = 1'b0;
        #4;
        check("mt_hilo", hilo, {32'h11, 32'h22});
        next_cycle();
        start = 1'b1;
        op    = MD_OP_DIVU;
        src_a = 32'd1000;
        src_b = 32'd3;
        repeat (10) next_cycle();
        #4;
        check("flush_pre_stall", 64'(stall), 64'd1);
        #1;
        flush = 1'b1;
        #1;
        check("flush_stall_same_cycle", 64'(stall), 64'd0);
        next_cycle();
        flush = 1'b0;
        start = 1'b0;
        #4;
        check("flush_after_stall", 64'(stall), 64'd0);
        check("flush_no_done", 64'(done), 64'd0);
        check("flush_hilo_kept", hilo, {32'h11, 32'h22});
        run_op('{"divu_9_3_after_flush", MD_OP_DIVU, 32'd9, 32'd3, {32'd0, 32'd3}, 33});

        // Reset in the middle of a divide, then moves in IDLE.
        next_cycle();
        start = 1'b1;
        op    = MD_OP_DIVU;
        src_a = 32'd50;
        src_b = 32'd7;
        repeat (5) next_cycle();
        rst = 1'b1;
        #4;
        check("midrst_stall", 64'(stall), 64'd0);
        next_cycle();
        rst   = 1'b0;
        start = 1'b0;
        #4;
        check("midrst_hilo", hilo, 64'd0);
        check("midrst_idle", 64'({stall, done}), 64'd0);
        next_cycle();
        we_lo = 1'b1;
        wdata = 32'h55;
        next_cycle();
        we_lo = 1'b0;
        we_hi = 1'b1;
        wdata = 32'h1234;
        next_cycle();
        we_hi = 1'b0;
        #4;
        check("mthi_lo_unchanged", hilo, {32'h1234, 32'h55});

        // A multiply right after, to confirm the unit is live again.
        run_op('{"mult_after_rst", MD_OP_MULT, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 3});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard stop in case something wedges the bench.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
